// File: rtl/lpf_audio_pkg.sv
// Shared constants for the 3.58 MHz audio path.
// Both the 48 kHz LPF and its decimating FIFO import this package, so the
// filter frame length is defined in one place.
//   LPF_FRAME_LEN : CE pulses per filter frame (default decimation ratio)
//   AUDIO_W       : audio sample width in bits
//   fifo_aw()     : FIFO pointer index width for a given depth
package lpf_audio_pkg;

  localparam int unsigned LPF_FRAME_LEN = 72;
  localparam int unsigned AUDIO_W       = 16;

  function automatic int unsigned fifo_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Small single-clock FIFO for audio stages.
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full. Storage is not reset.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset (clears pointers)
//   WR, WDATA  : write request and data; ignored when full unless RD pops
//   RD         : read request; ignored when empty
//   RDATA      : entry at the read pointer (unmasked, valid when !EMPTY)
//   EMPTY      : no entries held
//   FULL       : DEPTH entries held
//   LEVEL      : number of entries held
module audio_sync_fifo
  import lpf_audio_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      WR,
  input  logic [WIDTH-1:0]          WDATA,
  input  logic                      RD,
  output logic [WIDTH-1:0]          RDATA,
  output logic                      EMPTY,
  output logic                      FULL,
  output logic [fifo_aw(DEPTH):0]   LEVEL
);

  localparam int unsigned AW = fifo_aw(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign EMPTY = (wr_ptr_q == rd_ptr_q);
  assign FULL  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign LEVEL = wr_ptr_q - rd_ptr_q;

  // A write into a full FIFO is accepted only when a pop frees the slot on
  // the same edge; the slot being written is the one being read out.
  assign wr_en = WR & (~FULL | RD);
  assign rd_en = RD & ~EMPTY;

  assign RDATA = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= WDATA;
    end
  end

endmodule

// File: rtl/lpf48k_decim_fifo.sv
// Downstream stage of the 48 kHz LPF: captures one filter output every DECIM
// CE pulses, buffers it, and hands it to the mixer over valid/ready.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset (priority over all)
//   CE         : 3.58 MHz clock enable shared with the filter
//   IDATA      : filtered sample
//   ODATA      : head-of-FIFO sample, forced to 0 while empty
//   OVALID     : FIFO not empty
//   OREADY     : consumer takes ODATA this cycle
//   LEVEL      : entries held
//   OVF        : sticky overflow flag (a sample was dropped)
//   CLR_OVF    : clears OVF; a coincident new overflow wins
module lpf48k_decim_fifo
  import lpf_audio_pkg::*;
#(
  parameter int unsigned MSB   = AUDIO_W - 1,
  parameter int unsigned DECIM = LPF_FRAME_LEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CE,
  input  logic [MSB:0]            IDATA,
  output logic [MSB:0]            ODATA,
  output logic                    OVALID,
  input  logic                    OREADY,
  output logic [fifo_aw(DEPTH):0] LEVEL,
  output logic                    OVF,
  input  logic                    CLR_OVF
);

  localparam logic [7:0] PhLast = 8'(DECIM - 1);

  logic [7:0] ph_q;
  logic [7:0] ph_d;
  logic       push;
  logic       pop;
  logic       ovf_q;
  logic       ovf_set;
  logic       fifo_empty;
  logic       fifo_full;
  logic [MSB:0] fifo_rdata;

  // Phase counter: one push per DECIM CE pulses, on the last pulse of a frame.
  always_comb begin
    ph_d = ph_q;
    push = 1'b0;
    if (CE) begin
      if (ph_q == PhLast) begin
        ph_d = '0;
        push = 1'b1;
      end else begin
        ph_d = ph_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) ph_q <= '0;
    else       ph_q <= ph_d;
  end

  // OVALID is a pure function of the pointers, so OREADY never reaches it.
  assign pop     = ~fifo_empty & OREADY;
  assign ovf_set = push & fifo_full & ~pop;

  always_ff @(posedge CLK) begin
    if (RESET)        ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (CLR_OVF) ovf_q <= 1'b0;
  end

  audio_sync_fifo #(
    .WIDTH (MSB + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .WR    (push),
    .WDATA (IDATA),
    .RD    (pop),
    .RDATA (fifo_rdata),
    .EMPTY (fifo_empty),
    .FULL  (fifo_full),
    .LEVEL (LEVEL)
  );

  // Storage is never reset, so the read mux is masked to keep ODATA clean.
  assign ODATA  = fifo_empty ? '0 : fifo_rdata;
  assign OVALID = ~fifo_empty;
  assign OVF    = ovf_q;

endmodule
